// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator: register map, OBI channel types and the
// configuration-sequencer state encoding.
package cnn_pkg;

    localparam int unsigned NUM_WEIGHTS = 9;
    localparam int unsigned NUM_STEPS   = NUM_WEIGHTS + 3;

    localparam logic [31:0] CTRL_OFFSET        = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFFSET      = 32'h0000_0004;
    localparam logic [31:0] INPUT_BASE_OFFSET  = 32'h0000_0008;
    localparam logic [31:0] OUTPUT_BASE_OFFSET = 32'h0000_000C;
    localparam logic [31:0] WEIGHT_OFFSET      = 32'h0000_0010;

    localparam logic [31:0] CTRL_START = 32'h0000_0001;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic [0:0]  user;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic [0:0]  r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    typedef enum logic [2:0] {
        CFG_IDLE,
        CFG_WR_REQ,
        CFG_WR_RSP,
        CFG_POLL_REQ,
        CFG_POLL_RSP,
        CFG_DONE,
        CFG_ERR
    } cfg_state_t;

    function automatic logic [31:0] weight_offset(input int unsigned idx);
        return WEIGHT_OFFSET + 32'(4 * idx);
    endfunction

endpackage

// File: rtl/cnn_obi_txn.sv
// Single outstanding OBI transaction engine. The request is presented while go_i is held;
// ack_o pulses once the response phase completes (rvalid, or one cycle after a write grant).
module cnn_obi_txn
    import cnn_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        go_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output obi_req_t    obi_req_o,
    input  obi_rsp_t    obi_rsp_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic pending_q, pending_d;
    logic we_q, we_d;
    logic unused_rsp;

    assign unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

    always_comb begin
        obi_req_o = '0;
        if (go_i) begin
            obi_req_o.req     = 1'b1;
            obi_req_o.a.addr  = addr_i;
            obi_req_o.a.we    = we_i;
            obi_req_o.a.be    = '1;
            obi_req_o.a.wdata = wdata_i;
        end
    end

    // The subordinate never answers writes, so a write is considered complete in the
    // cycle after its grant whether or not rvalid shows up there.
    assign ack_o   = pending_q && (obi_rsp_i.rvalid || we_q);
    assign err_o   = pending_q && obi_rsp_i.rvalid && obi_rsp_i.r.err;
    assign rdata_o = obi_rsp_i.r.rdata;

    always_comb begin
        pending_d = pending_q;
        we_d      = we_q;
        if (ack_o) begin
            pending_d = 1'b0;
        end
        if (go_i && obi_rsp_i.gnt) begin
            pending_d = 1'b1;
            we_d      = we_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            we_q      <= we_d;
        end
    end

endmodule

// File: rtl/cnn_cfg_sequencer.sv
// OBI manager that programs one cnn_top job (weights, bases, CTRL) and then polls STATUS
// until the accelerator reports done, an OBI error occurs, or the poll budget runs out.
module cnn_cfg_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter logic [31:0] AccelBase   = 32'h2000_0000,
    parameter int unsigned PollTimeout = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [NUM_WEIGHTS-1:0][DATA_WIDTH-1:0] weights_i,
    input  logic [31:0]                            input_base_i,
    input  logic [31:0]                            output_base_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o,
    output obi_req_t                               mgr_obi_req_o,
    input  obi_rsp_t                               mgr_obi_rsp_i
);

    localparam int unsigned     CntW     = $clog2(PollTimeout + 1);
    localparam logic [CntW-1:0] PollLast = CntW'(PollTimeout - 1);
    localparam logic [3:0]      LastStep = 4'(NUM_STEPS - 1);

    cfg_state_t state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [CntW-1:0] poll_cnt_q, poll_cnt_d;
    logic [NUM_WEIGHTS-1:0][DATA_WIDTH-1:0] weights_q, weights_d;
    logic [31:0] in_base_q, in_base_d;
    logic [31:0] out_base_q, out_base_d;

    logic        txn_go, txn_we, txn_ack, txn_err;
    logic [31:0] txn_addr, txn_wdata, txn_rdata;
    logic        unused_rdata;

    logic [31:0] step_addr  [16];
    logic [31:0] step_wdata [16];

    // Address/data for every write step, indexed directly by step_q.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_step
            if (gi < NUM_WEIGHTS) begin : g_weight
                assign step_addr[gi]  = AccelBase + weight_offset(gi);
                assign step_wdata[gi] = {{(32-DATA_WIDTH){weights_q[gi][DATA_WIDTH-1]}},
                                         weights_q[gi]};
            end else if (gi == NUM_WEIGHTS) begin : g_in_base
                assign step_addr[gi]  = AccelBase + INPUT_BASE_OFFSET;
                assign step_wdata[gi] = in_base_q;
            end else if (gi == NUM_WEIGHTS + 1) begin : g_out_base
                assign step_addr[gi]  = AccelBase + OUTPUT_BASE_OFFSET;
                assign step_wdata[gi] = out_base_q;
            end else if (gi == NUM_WEIGHTS + 2) begin : g_ctrl
                assign step_addr[gi]  = AccelBase + CTRL_OFFSET;
                assign step_wdata[gi] = CTRL_START;
            end else begin : g_spare
                assign step_addr[gi]  = '0;
                assign step_wdata[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        poll_cnt_d = poll_cnt_q;
        weights_d  = weights_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        txn_go     = 1'b0;
        txn_we     = 1'b0;
        txn_addr   = '0;
        txn_wdata  = '0;

        unique case (state_q)
            CFG_IDLE: begin
                if (start_i) begin
                    weights_d  = weights_i;
                    in_base_d  = input_base_i;
                    out_base_d = output_base_i;
                    step_d     = '0;
                    poll_cnt_d = '0;
                    state_d    = CFG_WR_REQ;
                end
            end
            CFG_WR_REQ: begin
                txn_go    = 1'b1;
                txn_we    = 1'b1;
                txn_addr  = step_addr[step_q];
                txn_wdata = step_wdata[step_q];
                if (mgr_obi_rsp_i.gnt) begin
                    state_d = CFG_WR_RSP;
                end
            end
            CFG_WR_RSP: begin
                if (txn_err) begin
                    state_d = CFG_ERR;
                end else if (txn_ack) begin
                    if (step_q == LastStep) begin
                        poll_cnt_d = '0;
                        state_d    = CFG_POLL_REQ;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = CFG_WR_REQ;
                    end
                end
            end
            CFG_POLL_REQ: begin
                txn_go   = 1'b1;
                txn_addr = AccelBase + STATUS_OFFSET;
                if (mgr_obi_rsp_i.gnt) begin
                    state_d = CFG_POLL_RSP;
                end
            end
            CFG_POLL_RSP: begin
                if (txn_err) begin
                    state_d = CFG_ERR;
                end else if (txn_ack) begin
                    if (txn_rdata[0]) begin
                        state_d = CFG_DONE;
                    end else if (poll_cnt_q == PollLast) begin
                        state_d = CFG_ERR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + CntW'(1);
                        state_d    = CFG_POLL_REQ;
                    end
                end
            end
            CFG_DONE: state_d = CFG_IDLE;
            CFG_ERR:  state_d = CFG_IDLE;
            default:  state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CFG_IDLE;
            step_q     <= '0;
            poll_cnt_q <= '0;
            weights_q  <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            poll_cnt_q <= poll_cnt_d;
            weights_q  <= weights_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
        end
    end

    assign busy_o = (state_q != CFG_IDLE) && (state_q != CFG_DONE) && (state_q != CFG_ERR);
    assign done_o = (state_q == CFG_DONE);
    assign err_o  = (state_q == CFG_ERR);

    assign unused_rdata = ^txn_rdata[31:1];

    cnn_obi_txn u_txn (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .go_i      (txn_go),
        .we_i      (txn_we),
        .addr_i    (txn_addr),
        .wdata_i   (txn_wdata),
        .obi_req_o (mgr_obi_req_o),
        .obi_rsp_i (mgr_obi_rsp_i),
        .ack_o     (txn_ack),
        .rdata_o   (txn_rdata),
        .err_o     (txn_err)
    );

endmodule
